// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory / MMIO stage: MMIO register offsets,
// STATUS bit positions and the default MMIO page.
package dmem_pkg;

    localparam logic [15:0] DEFAULT_MMIO_PAGE = 16'hFFFF;

    localparam logic [15:0] OFF_TXDATA = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0004;
    localparam logic [15:0] OFF_CLEAR  = 16'h0008;
    localparam logic [15:0] OFF_CYCLES = 16'h000C;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_MSB = 15;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; drop flags a push refused because
// the queue is full and nothing leaves in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = store[rd_ptr];

    // NOTE: storage is deliberately left out of reset; only pointers and count
    // define validity, and a resettable array would cost a flop-reset per bit.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory stage: word RAM plus MMIO page with a TX FIFO drained over
// valid/ready. Optional free-running cycle counter at 0xC: DMEM_CYCLE_COUNTER_EN.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int          MEM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] MMIO_PAGE  = DEFAULT_MMIO_PAGE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        bus_valid,
    output logic [31:0] bus_data,
    input  logic        bus_ready,
    output logic        overflow
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             mmio;
    logic [15:0]      word_off;
    logic [IDX_W-1:0] ram_idx;
    logic             tx_wr;
    logic             clear_wr;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_drop;
    logic [31:0]      cycles_rd;
    logic             unused_addr_bits;

    logic [31:0] mem [MEM_WORDS];

    assign mmio             = (addr[31:16] == MMIO_PAGE);
    assign word_off         = {addr[15:2], 2'b00};
    assign ram_idx          = addr[IDX_W+1:2];
    assign tx_wr            = memwrite && mmio && (word_off == OFF_TXDATA);
    assign clear_wr         = memwrite && mmio && (word_off == OFF_CLEAR);
    assign unused_addr_bits = ^addr[1:0];

    always_ff @(posedge clk) begin
        if (memwrite && !mmio) begin
            mem[ram_idx] <= writedata;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_wr),
        .push_data (writedata),
        .pop       (bus_valid && bus_ready),
        .head      (bus_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    assign bus_valid = !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end else if (clear_wr) begin
            overflow <= 1'b0;
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic        cycles_wr;
    logic [31:0] cycles;

    assign cycles_wr = memwrite && mmio && (word_off == OFF_CYCLES);
    assign cycles_rd = cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
        end else if (cycles_wr) begin
            cycles <= writedata;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end
`else
    assign cycles_rd = 32'h0;
`endif

    // NOTE: readdata gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        readdata = '0;
        if (!mmio) begin
            readdata = mem[ram_idx];
        end else begin
            case (word_off)
                OFF_STATUS: begin
                    readdata[STAT_EMPTY]                     = fifo_empty;
                    readdata[STAT_FULL]                      = fifo_full;
                    readdata[STAT_OVERFLOW]                  = overflow;
                    readdata[STAT_COUNT_MSB:STAT_COUNT_LSB]  = 8'(fifo_count);
                end
                OFF_CYCLES: readdata = cycles_rd;
                default:    ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed plan steps followed by a random
// phase, all compared against a queue/array reference model.
module tb_dmem_mmio;

    localparam int MEM_WORDS = 64;
    localparam int DEPTH     = 4;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        bus_valid;
    logic [31:0] bus_data;
    logic        bus_ready;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mem_m [MEM_WORDS];
    logic [31:0] q_m [$];
    logic        ovf_m;
    logic [31:0] cyc_m;

    dmem_mmio #(
        .MEM_WORDS  (MEM_WORDS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_ready (bus_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, required finish before 400000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %08h required %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        int unsigned off;
        r   = 32'h0;
        off = a & 32'h0000_FFFF;
        if ((a >> 16) != 32'h0000_FFFF) begin
            r = mem_m[(a >> 2) % MEM_WORDS];
        end else if (off == 4) begin
            r = (q_m.size() << 8) | (32'(ovf_m) << 2)
              | ((q_m.size() == DEPTH) ? 32'd2 : 32'd0)
              | ((q_m.size() == 0) ? 32'd1 : 32'd0);
        end else if (off == 12) begin
`ifdef DMEM_CYCLE_COUNTER_EN
            r = cyc_m;
`else
            r = 32'h0;
`endif
        end
        return r;
    endfunction

    task automatic model_reset();
        q_m.delete();
        ovf_m = 1'b0;
        cyc_m = 32'h0;
    endtask

    // One clock edge of reference behaviour for the inputs held across it.
    task automatic model_step(input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic rdy);
        logic        mm;
        int unsigned off;
        logic [31:0] dummy;
        mm  = ((a >> 16) == 32'h0000_FFFF);
        off = a & 32'h0000_FFFF;
        if (rdy && q_m.size() != 0) dummy = q_m.pop_front();
        if (we && !mm) mem_m[(a >> 2) % MEM_WORDS] = d;
        if (we && mm && off == 0) begin
            if (q_m.size() < DEPTH) q_m.push_back(d);
            else                    ovf_m = 1'b1;
        end
        if (we && mm && off == 8) ovf_m = 1'b0;
        if (we && mm && off == 12) cyc_m = d;
        else                       cyc_m = cyc_m + 32'd1;
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_rd;
        exp_rd = model_read(addr);
        if (!$isunknown(exp_rd)) check({tag, "_rd"}, readdata, exp_rd);
        check({tag, "_valid"}, 32'(bus_valid), 32'(q_m.size() != 0));
        if (q_m.size() != 0) check({tag, "_data"}, bus_data, q_m[0]);
        check({tag, "_ovf"}, 32'(overflow), 32'(ovf_m));
    endtask

    // Entered and left at posedge+1: apply inputs, check, clock, update model.
    task automatic do_cycle(input string tag, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic rdy);
        memwrite  = we;
        addr      = a;
        writedata = d;
        bus_ready = rdy;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_step(we, a, d, rdy);
        #1;
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memwrite = 1'b0;
        addr     = a;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] mmio_offs [6];

        mmio_offs[0] = 32'h0; mmio_offs[1] = 32'h4; mmio_offs[2] = 32'h8;
        mmio_offs[3] = 32'hC; mmio_offs[4] = 32'h10; mmio_offs[5] = 32'h7FFC;

        reset = 1'b0; memwrite = 1'b0; addr = 32'h0; writedata = 32'h0; bus_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus_valid), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        peek("rst_status", 32'hFFFF_0004, 32'h0000_0001);
        peek("rst_cycles", 32'hFFFF_000C, 32'h0);
        addr = 32'h0;
        reset = 1'b1;
        @(posedge clk);
        model_step(1'b0, addr, 32'h0, 1'b0);
        #1;

        // RAM round trip, same-cycle read sees old data, alias wrap
        do_cycle("t1_wr", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        peek("t1_rd", 32'h10, 32'hDEAD_BEEF);
        peek("t1_alias", 32'h10 + 4 * MEM_WORDS, 32'hDEAD_BEEF);
        do_cycle("t1_wr2", 1'b1, 32'h110, 32'h1111_2222, 1'b0);
        peek("t1_rd2", 32'h10, 32'h1111_2222);

        // FIFO ordering
        for (int i = 1; i <= 3; i++) do_cycle("t2_push", 1'b1, 32'hFFFF_0000, 32'(i), 1'b0);
        peek("t2_status", 32'hFFFF_0004, 32'h0000_0300);
        check("t2_valid", 32'(bus_valid), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            check("t2_order", bus_data, 32'(i));
            do_cycle("t2_pop", 1'b0, 32'h100, 32'h0, 1'b1);
        end
        check("t2_empty_valid", 32'(bus_valid), 32'h0);
        peek("t2_empty_status", 32'hFFFF_0004, 32'h0000_0001);

        // Overflow and clear
        for (int i = 0; i < 5; i++) do_cycle("t3_push", 1'b1, 32'hFFFF_0000, 32'h10 + 32'(i), 1'b0);
        peek("t3_status", 32'hFFFF_0004, 32'h0000_0406);
        for (int i = 0; i < 4; i++) begin
            check("t3_order", bus_data, 32'h10 + 32'(i));
            do_cycle("t3_pop", 1'b0, 32'h100, 32'h0, 1'b1);
        end
        check("t3_no_fifth", 32'(bus_valid), 32'h0);
        do_cycle("t3_clear", 1'b1, 32'hFFFF_0008, 32'h1234, 1'b0);
        check("t3_ovf_clr", 32'(overflow), 32'h0);
        peek("t3_status_clr", 32'hFFFF_0004, 32'h0000_0001);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) do_cycle("t4_fill", 1'b1, 32'hFFFF_0000, 32'h20 + 32'(i), 1'b0);
        do_cycle("t4_pushpop", 1'b1, 32'hFFFF_0000, 32'hA5, 1'b1);
        peek("t4_status", 32'hFFFF_0004, 32'h0000_0402);
        for (int i = 0; i < 4; i++) do_cycle("t4_drain", 1'b0, 32'h100, 32'h0, 1'b1);
        check("t4_drained", 32'(bus_valid), 32'h0);

        // Async reset mid-drain with overflow set
        do_cycle("t5_ram", 1'b1, 32'h40, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 5; i++) do_cycle("t5_push", 1'b1, 32'hFFFF_0000, 32'h30 + 32'(i), 1'b0);
        for (int i = 0; i < 2; i++) do_cycle("t5_pop", 1'b0, 32'h100, 32'h0, 1'b1);
        check("t5_pre_ovf", 32'(overflow), 32'h1);
        bus_ready = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("t5_valid", 32'(bus_valid), 32'h0);
        check("t5_ovf", 32'(overflow), 32'h0);
        peek("t5_status", 32'hFFFF_0004, 32'h0000_0001);
        peek("t5_ram", 32'h40, 32'h1234_5678);
        reset = 1'b1;
        @(posedge clk);
        model_step(1'b0, addr, 32'h0, 1'b0);
        #1;

        // Cycle counter load and wrap (reads 0 when the feature is absent)
        do_cycle("t6_load", 1'b1, 32'hFFFF_000C, 32'hFFFF_FFFE, 1'b0);
        do_cycle("t6_c1", 1'b0, 32'hFFFF_000C, 32'h0, 1'b0);
        do_cycle("t6_c2", 1'b0, 32'hFFFF_000C, 32'h0, 1'b0);
        peek("t6_wrap", 32'hFFFF_000C, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 5) begin
                ra = $urandom & 32'hFFFF_FFFC;
                if ((ra >> 16) == 32'h0000_FFFF) ra = ra & 32'h7FFF_FFFF;
                if ($urandom_range(0, 1) == 1) ra = ra & 32'h0000_03FC;
            end else begin
                ra = 32'hFFFF_0000 | mmio_offs[$urandom_range(0, 5)];
            end
            do_cycle("rnd", 1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory stage directly downstream of the single-cycle core.
- Consumes the core's memwrite/aluout/writedata store port and produces readdata.
- Holds a word-addressed data RAM plus a small MMIO page. Stores to the MMIO TXDATA register are queued in a FIFO and drained to an external peripheral bus over a valid/ready handshake.

Parameters:
- MEM_WORDS, 64: data RAM depth in 32-bit words; power of 2.
- FIFO_DEPTH, 4: TX queue depth; power of 2, at least 2.
- MMIO_PAGE, 16'hFFFF: value of addr[31:16] that selects the MMIO page.

Ports:
- clk  in  1  core clock, all state on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- memwrite  in  1  store strobe from core.
- addr  in  32  byte address (core aluout).
- writedata  in  32  store data.
- readdata  out  32  load data, combinational from addr.
- bus_valid  out  1  FIFO head valid toward peripheral.
- bus_data  out  32  FIFO head word.
- bus_ready  in  1  peripheral accepts head this cycle.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
Address decode
- mmio = (addr[31:16] == MMIO_PAGE). Otherwise the access targets RAM.
- addr[1:0] ignored; no byte or halfword access.

RAM region
- Index = addr[$clog2(MEM_WORDS)+1:2]; higher bits alias (wrap-around).
- Read is combinational (the core is single-cycle, zero wait states).
- Write on posedge when memwrite && !mmio.
- RAM contents are not cleared by reset.
- A load and a store to the same word in one cycle returns old data; the new data is visible next cycle.

MMIO page (offset = addr[15:0]; other offsets read 0, writes ignored)
- 0x0 TXDATA:
  - Write: push writedata.
  - Read: returns 0.
- 0x4 STATUS (read-only):
  - [0] empty, [1] full, [2] overflow, [15:8] count (zero-extended), other bits 0.
- 0x8 CLEAR:
  - Write of any value clears overflow.
  - Read: returns 0.
- 0xC CYCLES: see Optional Feature.

TX FIFO
- bus_valid = !empty; bus_data = head word, combinational from storage (no extra latency).
- Pop on posedge when bus_valid && bus_ready.
- Push on posedge on a TXDATA write.
- Latency: a word pushed into an empty FIFO is visible on bus_valid/bus_data the next cycle.
- Full and push with no pop: word dropped, overflow set next cycle, count unchanged.
- Full with push and pop in the same cycle: both succeed, count unchanged, no overflow.
- Empty with pop: impossible, since bus_valid=0.
- Empty with push: count 0 -> 1.
- Pointers wrap modulo FIFO_DEPTH.
- count ranges 0..FIFO_DEPTH and needs $clog2(FIFO_DEPTH)+1 bits.
- bus_data is held stable while bus_valid && !bus_ready.

Reset (async assert, sync-safe deassert at the system level)
- FIFO pointers/count = 0; bus_valid = 0; bus_data undefined-but-ignored; overflow = 0; CYCLES = 0.
- Reset mid-transfer discards queued words; the peripheral must tolerate bus_valid dropping.
- readdata reflects the RAM/MMIO decode immediately after reset.

Optional Feature:
- Macro: DMEM_CYCLE_COUNTER_EN.
- Defined: 32-bit free-running counter, +1 every posedge, wraps 0xFFFFFFFF -> 0, reset 0, readable at offset 0xC. Writes to 0xC load the counter with writedata, and the load takes precedence over the increment that cycle.
- Undefined: offset 0xC reads 0, writes ignored, no counter flops.

Decomposition:
- Package dmem_pkg contains:
  - MMIO offset constants: OFF_TXDATA, OFF_STATUS, OFF_CLEAR, OFF_CYCLES.
  - STATUS bit-position constants.
  - Default MMIO_PAGE.
- One sub-module, sync_fifo, parameterised on width and depth. Ports: push, push_data, pop, head, empty, full, count, plus a drop output asserted on push-while-full-without-pop.
- dmem_mmio owns decode, RAM, the overflow flop and the optional counter.

Test Plan:
1. RAM round trip: store 0xDEADBEEF @0x10, next cycle load 0x10 -> readdata 0xDEADBEEF. Load @0x10+4*MEM_WORDS -> same value (alias).
2. FIFO order: bus_ready=0, store 0x1,0x2,0x3 to 0xFFFF0000 -> STATUS count 3, bus_valid=1, bus_data=0x1. Raise bus_ready 3 cycles -> bus_data 0x1,0x2,0x3 in order, then empty=1, bus_valid=0.
3. Overflow: bus_ready=0, 5 pushes with depth 4 -> STATUS 0x0406 (count 4, full, overflow), 5th word absent on drain. Write CLEAR -> overflow=0 next cycle.
4. Full with simultaneous push and pop: fill 4, bus_ready=1 plus push 0xA5 same cycle -> count stays 4, overflow stays 0, 0xA5 emerges last.
5. Async reset mid-drain: reset=0 between clk edges with 2 words queued -> bus_valid=0 and overflow=0 immediately. RAM word written before reset still reads back.
6. With DMEM_CYCLE_COUNTER_EN: write 0xFFFFFFFE to 0xFFFF000C, read 2 cycles later -> 0x00000000. Without the macro, same read -> 0.
